// File: rtl/types_pkg.sv
// Shared types and constants for the load/store path: the drain packet (lsq),
// the store-queue entry and the opcode/funct3 encodings the queue cares about.
package types_pkg;

    localparam int LSQ_DEPTH = 8;

    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SH  = 3'b001;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ps2_data;
        logic        sw_sh_signal;
        logic [4:0]  rob_tag;
    } lsq;

    typedef struct packed {
        logic        valid;
        logic        addr_valid;
        logic        committed;
        logic [4:0]  rob_tag;
        logic        sw_sh;
        logic [31:0] addr;
        logic [31:0] data;
    } lsq_entry_t;

    // Distance from the ROB head; smaller means older in program order.
    function automatic logic [4:0] rob_age(input logic [4:0] tag, input logic [4:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/lsq_overlap_check.sv
// Per-entry disambiguation: flags a store that is older than the querying load
// and either has no address yet or touches any byte the load reads.
module lsq_overlap_check
    import types_pkg::*;
(
    input  logic        st_valid,
    input  logic        st_addr_valid,
    input  logic        st_sw_sh,
    input  logic [4:0]  st_rob_tag,
    input  logic [31:0] st_addr,
    input  logic [4:0]  rob_head,
    input  logic [4:0]  ld_rob_tag,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_func3,
    output logic        conflict
);

    logic [32:0] st_end;
    logic [32:0] ld_end;
    logic        overlap;
    logic        older;

    // Ends are computed one bit wider so ranges near 0xFFFFFFFF do not wrap.
    assign st_end  = {1'b0, st_addr} + (st_sw_sh ? 33'd2 : 33'd4);
    assign ld_end  = {1'b0, ld_addr} + ((ld_func3 == F3_LBU) ? 33'd1 : 33'd4);
    assign overlap = ({1'b0, st_addr} < ld_end) && ({1'b0, ld_addr} < st_end);
    assign older   = rob_age(st_rob_tag, rob_head) < rob_age(ld_rob_tag, rob_head);

    assign conflict = st_valid && older && (!st_addr_valid || overlap);

endmodule

// File: rtl/load_store_queue.sv
// In-order store queue: allocate at dispatch, capture address/data at execute,
// commit at ROB retire and drain one committed store per cycle to data memory.
module load_store_queue
    import types_pkg::*;
#(
    parameter int DEPTH = LSQ_DEPTH
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_rob_tag,
    input  logic        alloc_sw_sh,
    output logic        full,
    output logic        empty,
    input  logic        st_exec_valid,
    input  logic [4:0]  st_exec_rob_tag,
    input  logic [31:0] st_exec_addr,
    input  logic [31:0] st_exec_data,
    input  logic        rob_retire_valid,
    input  logic [4:0]  rob_retire_tag,
    input  logic [4:0]  rob_head,
    input  logic        ld_check_valid,
    input  logic [4:0]  ld_check_rob_tag,
    input  logic [31:0] ld_check_addr,
    input  logic [2:0]  ld_check_func3,
    output logic        load_mem,
    input  logic        flush,
    output logic        store_wb,
    output lsq          lsq_in,
    output logic        proto_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    lsq_entry_t       entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] unc_ptr;
    logic [PTR_W-1:0] flush_tail;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] unc_off;
    logic [IDX_W-1:0] unc_idx;
    logic             unc_found;
    logic             retire_hit;
    logic             drain;
    logic [DEPTH-1:0] conflict;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign count    = tail - head;
    assign full     = (count == PTR_W'(DEPTH));
    assign empty    = (count == '0);

    // Oldest uncommitted entry; commits are in order, so everything before it is committed.
    always_comb begin
        unc_found = 1'b0;
        unc_off   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!unc_found && entries[head_idx + IDX_W'(k)].valid &&
                !entries[head_idx + IDX_W'(k)].committed) begin
                unc_found = 1'b1;
                unc_off   = IDX_W'(k);
            end
        end
    end

    assign unc_idx    = head_idx + unc_off;
    assign unc_ptr    = head + PTR_W'(unc_off);
    assign retire_hit = rob_retire_valid && unc_found && entries[unc_idx].addr_valid &&
                        (entries[unc_idx].rob_tag == rob_retire_tag);
    // A retire of the head entry drains in the same edge so store_wb follows one cycle later.
    assign drain      = entries[head_idx].valid &&
                        (entries[head_idx].committed || (retire_hit && unc_off == '0));
    assign flush_tail = unc_found ? unc_ptr + PTR_W'(retire_hit) : tail;

    for (genvar g = 0; g < DEPTH; g++) begin : g_chk
        lsq_overlap_check u_chk (
            .st_valid      (entries[g].valid),
            .st_addr_valid (entries[g].addr_valid),
            .st_sw_sh      (entries[g].sw_sh),
            .st_rob_tag    (entries[g].rob_tag),
            .st_addr       (entries[g].addr),
            .rob_head      (rob_head),
            .ld_rob_tag    (ld_check_rob_tag),
            .ld_addr       (ld_check_addr),
            .ld_func3      (ld_check_func3),
            .conflict      (conflict[g])
        );
    end

    assign load_mem = ld_check_valid && (conflict == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head      <= '0;
            tail      <= '0;
            store_wb  <= 1'b0;
            lsq_in    <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            store_wb <= drain;

            if (retire_hit) begin
                entries[unc_idx].committed <= 1'b1;
            end
            if ((rob_retire_valid && !retire_hit) || (alloc_valid && full && !flush)) begin
                proto_err <= 1'b1;
            end

            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].valid && !entries[i].committed &&
                        !(retire_hit && IDX_W'(i) == unc_idx)) begin
                        entries[i].valid <= 1'b0;
                    end
                end
                tail <= flush_tail;
            end else begin
                if (st_exec_valid) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (entries[i].valid && !entries[i].committed &&
                            entries[i].rob_tag == st_exec_rob_tag) begin
                            entries[i].addr_valid <= 1'b1;
                            entries[i].addr       <= st_exec_addr;
                            entries[i].data       <= st_exec_data;
                        end
                    end
                end
                if (alloc_valid && !full) begin
                    entries[tail_idx] <= '{valid: 1'b1, addr_valid: 1'b0, committed: 1'b0,
                                           rob_tag: alloc_rob_tag, sw_sh: alloc_sw_sh,
                                           addr: '0, data: '0};
                    tail <= tail + PTR_W'(1);
                end
            end

            if (drain) begin
                lsq_in <= '{addr: entries[head_idx].addr, ps2_data: entries[head_idx].data,
                            sw_sh_signal: entries[head_idx].sw_sh,
                            rob_tag: entries[head_idx].rob_tag};
                entries[head_idx].valid     <= 1'b0;
                entries[head_idx].committed <= 1'b0;
                head <= head + PTR_W'(1);
            end
        end
    end

endmodule
